four_bit_up_counter_ctrl: RTL and testbench



---
 rtl/four_bit_up_counter_ctrl_if.sv | 27 ++
 rtl/four_bit_up_counter_ctrl.sv | 101 ++++++++++
 tb/tb_four_bit_up_counter_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/four_bit_up_counter_ctrl_if.sv
// Control/status bundle for the programmable up counter.
// The master side drives the controls and the slave (the counter) drives the
// count and status flags.
interface four_bit_up_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output start, en, mode, limit, load, load_val,
        input  out, tc, busy, done
    );

    modport slave (
        input  start, en, mode, limit, load, load_val,
        output out, tc, busy, done
    );
endinterface

// File: rtl/four_bit_up_counter_ctrl.sv
// Programmable up counter with start/one-shot control FSM.
// Counts 0..limit while enabled in RUN. At terminal count it either wraps
// to 0 (free-running) or freezes in HOLD (one-shot). start restarts from 0
// and latches the mode. load overrides the count, and in HOLD it returns the
// FSM to IDLE. Priority at a clock edge is start, then load, then count.
module four_bit_up_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input logic                          clk,
    input logic                          rst,
    four_bit_up_counter_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_s;
    logic             mode_r;
    logic             mode_s;
    logic             tc_s;

    // Terminal count is only meaningful on an enabled RUN cycle. Because the
    // comparison is >=, a loaded value above limit also hits terminal count.
    always_comb begin
        tc_s = 1'b0;
        if ((state_r == RUN) && bus.en && (out_r >= bus.limit)) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    // Next-state and next-count logic with start > load > count priority.
    // The increment is only taken below the limit, so it never overflows.
    always_comb begin
        state_s = state_r;
        out_s   = out_r;
        mode_s  = mode_r;
        if (bus.start) begin
            state_s = RUN;
            out_s   = {WIDTH{1'b0}};
            mode_s  = bus.mode;
        end else if (bus.load) begin
            out_s = bus.load_val;
            if (state_r == HOLD) begin
                state_s = IDLE;
            end else begin
                state_s = state_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (!bus.en) begin
                        out_s = out_r;
                    end else if (!tc_s) begin
                        out_s = out_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else if (mode_r) begin
                        state_s = HOLD;
                    end else begin
                        out_s = {WIDTH{1'b0}};
                    end
                end
                HOLD: begin
                    state_s = HOLD;
                end
                default: begin
                    state_s = IDLE;
                    out_s   = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State, count and latched-mode registers; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            out_r   <= {WIDTH{1'b0}};
            mode_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            out_r   <= out_s;
            mode_r  <= mode_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.tc   = tc_s;
    assign bus.busy = (state_r == RUN);
    assign bus.done = (state_r == HOLD);

endmodule

// File: tb/tb_four_bit_up_counter_ctrl.sv
// Self-checking bench for four_bit_up_counter_ctrl. A behavioural model
// predicts each cycle; expected post-edge values are queued when stimulus is
// driven and popped for comparison after the edge.
module tb_four_bit_up_counter_ctrl;

    localparam int W = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HOLD = 2;

    typedef struct {
        logic [W-1:0] out;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk;
    logic rst;

    four_bit_up_counter_ctrl_if #(.WIDTH(W)) bus ();

    four_bit_up_counter_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           passed = 0;
    int           total  = 0;
    exp_t         sb[$];
    int           m_state;
    logic [W-1:0] m_out;
    logic         m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_out   = '0;
        m_mode  = 1'b0;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), check tc
    // mid-cycle, then check the registered results after the next edge.
    task automatic cyc(input logic s, input logic ld, input logic e, input logic m,
                       input logic [W-1:0] lim, input logic [W-1:0] lv);
        logic m_tc;
        exp_t item;
        bus.start    = s;
        bus.load     = ld;
        bus.en       = e;
        bus.mode     = m;
        bus.limit    = lim;
        bus.load_val = lv;
        m_tc = (m_state == S_RUN) && e && (m_out >= lim);
        if (s) begin
            m_state = S_RUN;
            m_out   = '0;
            m_mode  = m;
        end else if (ld) begin
            m_out = lv;
            if (m_state == S_HOLD) m_state = S_IDLE;
        end else if (m_state == S_RUN && e) begin
            if (!m_tc)       m_out = m_out + 4'd1;
            else if (m_mode) m_state = S_HOLD;
            else             m_out = 4'd0;
        end
        sb.push_back('{out: m_out, busy: (m_state == S_RUN), done: (m_state == S_HOLD)});
        @(negedge clk);
        check("tc", {31'd0, bus.tc}, {31'd0, m_tc});
        @(posedge clk);
        #1;
        item = sb.pop_front();
        check("out",  {28'd0, bus.out}, {28'd0, item.out});
        check("busy", {31'd0, bus.busy}, {31'd0, item.busy});
        check("done", {31'd0, bus.done}, {31'd0, item.done});
        check("excl", {31'd0, bus.busy & bus.done}, 32'd0);
    endtask

    // Upper bound on simulation time so the bench can never hang.
    initial begin
        #200000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.mode = 1'b0;
        bus.limit = 4'd0; bus.load_val = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out",  {28'd0, bus.out}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_tc",   {31'd0, bus.tc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a RUN phase with out=7.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd12, 4'd0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 4'd0);
        check("pre_rst_out", {28'd0, bus.out}, 32'd7);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_out",  {28'd0, bus.out}, 32'd0);
        check("async_busy", {31'd0, bus.busy}, 32'd0);
        check("async_done", {31'd0, bus.done}, 32'd0);
        check("async_tc",   {31'd0, bus.tc}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd12, 4'd0);
        check("post_rst_idle", {28'd0, bus.out}, 32'd0);

        // Free-running wrap, limit 9.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0);
        for (int i = 0; i < 25; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd0);
        check("wrap_seq", {28'd0, bus.out}, 32'd5);

        // One-shot to limit 5, then restart.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0);
        check("oneshot_out",  {28'd0, bus.out}, 32'd5);
        check("oneshot_done", {31'd0, bus.done}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd0);
        check("restart_busy", {31'd0, bus.busy}, 32'd1);

        // Enable gating and full range, limit 15.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0);
        check("gated_out", {28'd0, bus.out}, 32'd3);
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 4'd0);
        check("full_wrap", {28'd0, bus.out}, 32'd1);

        // Load above limit in RUN, then start+load priority.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd10, 4'd12);
        check("load_out", {28'd0, bus.out}, 32'd12);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd0);
        check("load_wrap", {28'd0, bus.out}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd10, 4'd9);
        check("start_beats_load", {28'd0, bus.out}, 32'd0);

        // Limit zero in one-shot, then load out of HOLD.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        check("lim0_done", {31'd0, bus.done}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6);
        check("hold_load_idle", {31'd0, bus.busy | bus.done}, 32'd0);

        // Random mix, including limit changes and mode changes mid-run.
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
